// File: rtl/matvec_result_collector.sv
// Collects the matrix-vector multiplier's per-row results. Each row gets a bias add with
// saturation and an optional activation. Rows are stored in a buffer that is read through a registered port.
module matvec_result_collector #(
  parameter int MAX_ROWS   = 64,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 12
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [$clog2(MAX_ROWS):0]     num_rows,
  input  logic [1:0]                    act_sel,
  input  logic                          bias_write_enable,
  input  logic [$clog2(MAX_ROWS)-1:0]   bias_addr,
  input  logic [DATA_WIDTH-1:0]         bias_in,
  input  logic [DATA_WIDTH-1:0]         result_in,
  input  logic                          result_valid_in,
  input  logic [$clog2(MAX_ROWS)-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          busy,
  output logic                          done
);
  localparam int AW = $clog2(MAX_ROWS);
  localparam int NW = AW + 1;
  localparam logic signed [DATA_WIDTH-1:0] ACT_ONE  = DATA_WIDTH'(1 << FRAC_BITS);
  localparam logic signed [DATA_WIDTH-1:0] ACT_HALF = DATA_WIDTH'(1 << (FRAC_BITS - 1));
  localparam logic signed [DATA_WIDTH-1:0] ACT_NEG_ONE = -ACT_ONE;
  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [NW-1:0]           eff_rows_q, eff_rows_d;
  logic [1:0]              act_q, act_d;
  logic [NW-1:0]           row_idx_q, row_idx_d;
  logic                    s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0]   s1_data_q, s1_data_d;
  logic [AW-1:0]           s1_row_q, s1_row_d;
  logic                    s1_last_q, s1_last_d;
  logic                    done_q, done_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;

  logic [DATA_WIDTH-1:0]   bias_mem [MAX_ROWS];
  logic [DATA_WIDTH-1:0]   buf_mem  [MAX_ROWS];

  logic                         bias_we;
  logic [DATA_WIDTH-1:0]        bias_rd;
  logic signed [DATA_WIDTH:0]   sum_wide;
  logic signed [DATA_WIDTH-1:0] sat_x;
  logic signed [DATA_WIDTH-1:0] sig_x;
  logic signed [DATA_WIDTH-1:0] act_y;

  // Bias add at one extra bit, then saturate back into the word before the activation.
  always_comb begin
    bias_rd  = bias_mem[row_idx_q[AW-1:0]];
    sum_wide = {result_in[DATA_WIDTH-1], result_in} + {bias_rd[DATA_WIDTH-1], bias_rd};
    sat_x    = sum_wide[DATA_WIDTH-1:0];
    if (sum_wide[DATA_WIDTH] != sum_wide[DATA_WIDTH-1]) begin
      sat_x = sum_wide[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    end
    sig_x = (sat_x >>> 2) + ACT_HALF;
    act_y = sat_x;
    case (act_q)
      2'd1: act_y = sat_x[DATA_WIDTH-1] ? '0 : sat_x;
      2'd2: begin
        if (sig_x[DATA_WIDTH-1])  act_y = '0;
        else if (sig_x > ACT_ONE) act_y = ACT_ONE;
        else                      act_y = sig_x;
      end
      2'd3: begin
        if (sat_x > ACT_ONE)          act_y = ACT_ONE;
        else if (sat_x < ACT_NEG_ONE) act_y = ACT_NEG_ONE;
        else                          act_y = sat_x;
      end
      default: act_y = sat_x;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    eff_rows_d = eff_rows_q;
    act_d      = act_q;
    row_idx_d  = row_idx_q;
    s1_valid_d = 1'b0;
    s1_data_d  = s1_data_q;
    s1_row_d   = s1_row_q;
    s1_last_d  = s1_last_q;
    done_d     = 1'b0;
    bias_we    = 1'b0;
    rd_data_d  = buf_mem[rd_addr];
    case (state_q)
      IDLE: begin
        bias_we = bias_write_enable;
        if (start) begin
          eff_rows_d = (num_rows > NW'(MAX_ROWS)) ? NW'(MAX_ROWS) : num_rows;
          act_d      = act_sel;
          row_idx_d  = '0;
          if (eff_rows_d == '0) done_d  = 1'b1;
          else                  state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (result_valid_in && (row_idx_q < eff_rows_q)) begin
          s1_valid_d = 1'b1;
          s1_data_d  = act_y;
          s1_row_d   = row_idx_q[AW-1:0];
          s1_last_d  = ((row_idx_q + NW'(1)) == eff_rows_q);
          row_idx_d  = row_idx_q + NW'(1);
        end
        // Capture ends on the edge that writes the final row.
        if (s1_valid_q && s1_last_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      eff_rows_q <= '0;
      act_q      <= '0;
      row_idx_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_row_q   <= '0;
      s1_last_q  <= 1'b0;
      done_q     <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      eff_rows_q <= eff_rows_d;
      act_q      <= act_d;
      row_idx_q  <= row_idx_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_row_q   <= s1_row_d;
      s1_last_q  <= s1_last_d;
      done_q     <= done_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Memories are not reset; the stage-1 valid is, so reset stops further writes.
  always_ff @(posedge clk) begin
    if (s1_valid_q) buf_mem[s1_row_q]   <= s1_data_q;
    if (bias_we)    bias_mem[bias_addr] <= bias_in;
  end

  assign rd_data = rd_data_q;
  assign busy    = (state_q == COLLECT);
  assign done    = done_q;
endmodule

// File: tb/tb_matvec_result_collector.sv
// Randomized bench for matvec_result_collector. A behavioural model computes each row from
// integer arithmetic, and buffer readback is checked through an expected queue.
module tb_matvec_result_collector;
  localparam int MR = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  num_rows = '0;
  logic [1:0]  act_sel = '0;
  logic        bias_write_enable = 1'b0;
  logic [5:0]  bias_addr = '0;
  logic [15:0] bias_in = '0;
  logic [15:0] result_in = '0;
  logic        result_valid_in = 1'b0;
  logic [5:0]  rd_addr = '0;
  logic [15:0] rd_data;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] stim    [MR];
  logic [15:0] exp_buf [MR];
  logic [15:0] bias_m  [MR];

  matvec_result_collector #(.MAX_ROWS(64), .DATA_WIDTH(16), .FRAC_BITS(12)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_rows(num_rows), .act_sel(act_sel),
    .bias_write_enable(bias_write_enable), .bias_addr(bias_addr), .bias_in(bias_in),
    .result_in(result_in), .result_valid_in(result_valid_in), .rd_addr(rd_addr),
    .rd_data(rd_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] ref_row(input logic [15:0] r, input logic [15:0] b, input int act);
    int x;
    int y;
    x = int'($signed(r)) + int'($signed(b));
    if (x > 32767)  x = 32767;
    if (x < -32768) x = -32768;
    case (act)
      1: y = (x < 0) ? 0 : x;
      2: begin
        y = (x >>> 2) + 2048;
        if (y < 0)    y = 0;
        if (y > 4096) y = 4096;
      end
      3: begin
        y = x;
        if (y > 4096)  y = 4096;
        if (y < -4096) y = -4096;
      end
      default: y = x;
    endcase
    return y[15:0];
  endfunction

  task automatic load_bias(input int addr, input logic [15:0] v);
    bias_write_enable = 1'b1;
    bias_addr = 6'(addr);
    bias_in = v;
    @(negedge clk);
    bias_write_enable = 1'b0;
    bias_m[addr] = v;
  endtask

  task automatic check_rows(input int first, input int n, input string tag);
    logic [15:0] e;
    for (int i = first; i < first + n; i++) exp_q.push_back(exp_buf[i]);
    for (int i = first; i < first + n; i++) begin
      rd_addr = 6'(i);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (rd_data !== e) begin
        errors++;
        $display("FAIL %s row %0d: got %h expected %h", tag, i, rd_data, e);
      end
    end
  endtask

  task automatic run_capture(input int n, input int act, input int gap, input bit poke,
                             input bit tail_junk, input string tag);
    int eff;
    eff = (n > MR) ? MR : n;
    start = 1'b1;
    num_rows = 7'(n);
    act_sel = 2'(act);
    @(negedge clk);
    start = 1'b0;
    if (eff == 0) begin
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL %s zero-row start: done=%b busy=%b expected done=1 busy=0", tag, done, busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL %s zero-row after: done=%b busy=%b expected 0 0", tag, done, busy);
      end
      return;
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy after start: got %b expected 1", tag, busy);
    end
    for (int i = 0; i < eff; i++) begin
      exp_buf[i] = ref_row(stim[i], bias_m[i], act);
      result_valid_in = 1'b1;
      result_in = stim[i];
      if (poke && i == 1) begin
        start = 1'b1;
        num_rows = 7'd2;
        act_sel = 2'(act ^ 1);
        bias_write_enable = 1'b1;
        bias_addr = 6'd2;
        bias_in = 16'h1234;
      end
      @(negedge clk);
      result_valid_in = 1'b0;
      start = 1'b0;
      bias_write_enable = 1'b0;
      if (i < eff - 1) repeat (gap) @(negedge clk);
    end
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s one edge after last valid: done=%b busy=%b expected 0 1", tag, done, busy);
    end
    result_valid_in = tail_junk;
    result_in = 16'($urandom);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s two edges after last valid: done=%b busy=%b expected 1 0", tag, done, busy);
    end
    result_in = 16'($urandom);
    @(negedge clk);
    result_valid_in = 1'b0;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s done pulse width: got %b expected 0", tag, done);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || rd_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b rd_data=%h expected 0 0 0000", busy, done, rd_data);
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) load_bias(i, 16'h0000);
    stim[0] = 16'd2048; stim[1] = 16'd4096; stim[2] = 16'hF000; stim[3] = 16'h2000;
    run_capture(4, 0, 0, 1'b0, 1'b0, "basic");
    check_rows(0, 4, "basic");
  endtask

  task automatic test_saturation();
    load_bias(0, 16'h2000);
    stim[0] = 16'h7000;
    run_capture(1, 0, 0, 1'b0, 1'b0, "sat_pos");
    check_rows(0, 1, "sat_pos");
    load_bias(0, 16'h8000);
    stim[0] = 16'hC000;
    run_capture(1, 0, 0, 1'b0, 1'b0, "sat_neg");
    check_rows(0, 1, "sat_neg");
  endtask

  task automatic test_activation();
    for (int i = 0; i < 4; i++) load_bias(i, 16'h0000);
    stim[0] = 16'd0; stim[1] = 16'd8192; stim[2] = 16'hC000; stim[3] = 16'd4096;
    run_capture(4, 2, 0, 1'b0, 1'b0, "hsig");
    check_rows(0, 4, "hsig");
    stim[0] = 16'd12288; stim[1] = 16'hF800;
    run_capture(2, 3, 0, 1'b0, 1'b0, "htanh");
    check_rows(0, 2, "htanh");
    stim[0] = 16'hF000; stim[1] = 16'd1234;
    run_capture(2, 1, 1, 1'b0, 1'b0, "relu");
    check_rows(0, 2, "relu");
  endtask

  task automatic test_zero_rows();
    run_capture(0, 0, 0, 1'b0, 1'b0, "zero_rows");
    result_valid_in = 1'b1;
    result_in = 16'h5555;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_valid busy: got %b expected 0", busy);
      end
    end
    result_valid_in = 1'b0;
    check_rows(0, 2, "idle_valid");
  endtask

  task automatic test_overflow_rows();
    for (int i = 0; i < MR; i++) begin
      load_bias(i, 16'($urandom));
      stim[i] = 16'($urandom);
    end
    run_capture(MR + 1, int'($urandom_range(0, 3)), 0, 1'b0, 1'b1, "overflow");
    check_rows(0, MR, "overflow");
  endtask

  task automatic test_gapped();
    logic [15:0] keep [8];
    for (int i = 0; i < 8; i++) begin
      load_bias(i, 16'($urandom));
      stim[i] = 16'($urandom);
      keep[i] = stim[i];
    end
    run_capture(8, 0, 0, 1'b0, 1'b0, "continuous");
    check_rows(0, 8, "continuous");
    for (int i = 0; i < 8; i++) stim[i] = ~keep[i];
    run_capture(8, 0, 0, 1'b0, 1'b0, "scramble");
    for (int i = 0; i < 8; i++) stim[i] = keep[i];
    run_capture(8, 0, 3, 1'b0, 1'b0, "gapped");
    check_rows(0, 8, "gapped");
  endtask

  task automatic test_ignored_controls();
    for (int i = 0; i < 4; i++) begin
      load_bias(i, 16'($urandom_range(0, 16'h0FFF)));
      stim[i] = 16'($urandom_range(0, 16'h3FFF));
    end
    run_capture(4, 0, 0, 1'b1, 1'b0, "ctrl_poke");
    check_rows(0, 4, "ctrl_poke");
    for (int i = 0; i < 4; i++) stim[i] = 16'($urandom);
    run_capture(4, 3, 0, 1'b0, 1'b0, "ctrl_after");
    check_rows(0, 4, "ctrl_after");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) stim[i] = 16'($urandom);
    start = 1'b1;
    num_rows = 7'd4;
    act_sel = 2'd0;
    @(negedge clk);
    start = 1'b0;
    exp_buf[0] = ref_row(stim[0], bias_m[0], 0);
    for (int i = 0; i < 2; i++) begin
      result_valid_in = 1'b1;
      result_in = stim[i];
      @(negedge clk);
    end
    result_valid_in = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b expected 0 0", busy, done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_rows(0, 2, "reset_partial");
    for (int i = 0; i < 4; i++) stim[i] = 16'($urandom);
    run_capture(4, 2, 0, 1'b0, 1'b0, "after_reset");
    check_rows(0, 4, "after_reset");
  endtask

  task automatic test_random();
    int n;
    for (int k = 0; k < 6; k++) begin
      n = int'($urandom_range(1, 10));
      for (int i = 0; i < n; i++) begin
        load_bias(i, 16'($urandom));
        stim[i] = 16'($urandom);
      end
      run_capture(n, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b0, 1'b0, "random");
      check_rows(0, n, "random");
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_saturation();
    test_activation();
    test_zero_rows();
    test_overflow_rows();
    test_gapped();
    test_ignored_controls();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
